// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable sequence detector.
package seq_det_pkg;

    // Controller states: unconfigured, detecting, illegal configuration
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // Width needed to hold a length value 0..max_len
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Pattern mask helper: bit idx takes part in the compare when idx < len
    function automatic logic mask_bit(input int idx, input int len);
        return (idx < len);
    endfunction

endpackage

// File: rtl/seq_det_hist.sv
// History shift register and fill counter for the sequence detector.
// o_win is the compare window {hist, current bit}; newest bit at [0].
module seq_det_hist #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic               i_fill_clr,
    input  logic               i_bit,
    output logic [MAX_LEN-1:0] o_win,
    output logic [LEN_W-1:0]   o_fill
);

    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] w_win;

    assign w_win  = {r_hist, i_bit};
    assign o_win  = w_win;
    assign o_fill = r_fill;

    // Shift accepted bits in; clear has priority so a reload starts clean
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_hist <= '0;
        end else if (i_clear) begin
            r_hist <= '0;
        end else if (i_shift) begin
            r_hist <= w_win[MAX_LEN-2:0];
        end
    end

    // Count accepted bits, saturating at MAX_LEN; a non-overlapping hit restarts it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fill <= '0;
        end else if (i_clear) begin
            r_fill <= '0;
        end else if (i_shift) begin
            if (i_fill_clr) begin
                r_fill <= '0;
            end else if (r_fill != LEN_W'(MAX_LEN)) begin
                r_fill <= r_fill + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector.
// Pattern bit[len-1] is the first bit received, bit[0] the last.
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_detect_prog
    import seq_det_pkg::*;
#(
    parameter  int MAX_LEN        = 8,
    parameter  int REGISTERED_OUT = 0,
`ifdef SEQ_DET_MATCH_CNT_EN
    parameter  int CNT_W          = 16,
`endif
    localparam int LEN_W          = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_cfg_load,
    input  logic [MAX_LEN-1:0] i_cfg_pattern,
    input  logic [LEN_W-1:0]   i_cfg_len,
    input  logic               i_cfg_overlap,
    input  logic               i_in_valid,
    input  logic               i_in_bit,
    output logic               o_match,
    output logic               o_cfg_err
`ifdef SEQ_DET_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]   o_match_cnt
`endif
);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [MAX_LEN-1:0] r_pattern;
    logic [LEN_W-1:0]   r_len;
    logic               r_overlap;

    logic               w_len_ok;
    logic               w_shift;
    logic               w_fill_ok;
    logic               w_win_eq;
    logic               w_match_now;
    logic               w_fill_clr;
    logic [MAX_LEN-1:0] w_win;
    logic [MAX_LEN-1:0] w_mask;
    logic [LEN_W-1:0]   w_fill;

    assign w_len_ok = (i_cfg_len != '0) && (i_cfg_len <= LEN_W'(MAX_LEN));

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: any load re-evaluates the length, from every state
    always_comb begin
        w_state_nxt = r_state;
        if (i_cfg_load) begin
            w_state_nxt = w_len_ok ? ST_RUN : ST_ERR;
        end
    end

    assign o_cfg_err = (r_state == ST_ERR);

    // Configuration capture; stored even when illegal, ERR state blocks use
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pattern <= '0;
            r_len     <= '0;
            r_overlap <= 1'b0;
        end else if (i_cfg_load) begin
            r_pattern <= i_cfg_pattern;
            r_len     <= i_cfg_len;
            r_overlap <= i_cfg_overlap;
        end
    end

    // A load in the same cycle as a valid bit discards the bit
    assign w_shift = (r_state == ST_RUN) & i_in_valid & ~i_cfg_load;

    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign w_mask[gi] = mask_bit(gi, int'(r_len));
    end

    assign w_win_eq    = (((w_win ^ r_pattern) & w_mask) == '0);
    assign w_fill_ok   = (({1'b0, w_fill} + (LEN_W+1)'(1)) >= {1'b0, r_len});
    assign w_match_now = w_shift & w_fill_ok & w_win_eq;
    assign w_fill_clr  = w_match_now & ~r_overlap;

    seq_det_hist #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_hist (
        .clk        (clk),
        .rstn       (rstn),
        .i_clear    (i_cfg_load),
        .i_shift    (w_shift),
        .i_fill_clr (w_fill_clr),
        .i_bit      (i_in_bit),
        .o_win      (w_win),
        .o_fill     (w_fill)
    );

    if (REGISTERED_OUT != 0) begin : g_reg_out
        logic r_match;
        // Registered match: a later reload does not cancel a pulse already taken
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) r_match <= 1'b0;
            else       r_match <= w_match_now;
        end
        assign o_match = r_match;
    end else begin : g_comb_out
        assign o_match = w_match_now;
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;
    // Saturating occurrence counter, restarted by every load
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_cfg_load) begin
            r_cnt <= '0;
        end else if (w_match_now && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
    assign o_match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: one Mealy-timed and one registered instance share stimulus.
module tb_seq_detect_prog;

    logic       clk;
    logic       rstn;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       in_valid;
    logic       in_bit;
    logic       match0, match1;
    logic       err0, err1;
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [15:0] cnt0;
    logic [1:0]  cnt1;
`endif

    int checks   = 0;
    int failures = 0;
    int hits0    = 0;
    int hits1    = 0;

    // reference model state
    bit       m_cfgd;
    bit       m_err;
    bit [7:0] m_pat;
    int       m_len;
    bit       m_ovl;
    bit       m_prev;
    bit       fresh[$];
    int       m_cnt0;
    int       m_cnt1;

    seq_detect_prog #(
        .MAX_LEN(8), .REGISTERED_OUT(0)
`ifdef SEQ_DET_MATCH_CNT_EN
        , .CNT_W(16)
`endif
    ) u_dut0 (
        .clk(clk), .rstn(rstn), .i_cfg_load(cfg_load), .i_cfg_pattern(cfg_pattern),
        .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_in_valid(in_valid),
        .i_in_bit(in_bit), .o_match(match0), .o_cfg_err(err0)
`ifdef SEQ_DET_MATCH_CNT_EN
        , .o_match_cnt(cnt0)
`endif
    );

    seq_detect_prog #(
        .MAX_LEN(8), .REGISTERED_OUT(1)
`ifdef SEQ_DET_MATCH_CNT_EN
        , .CNT_W(2)
`endif
    ) u_dut1 (
        .clk(clk), .rstn(rstn), .i_cfg_load(cfg_load), .i_cfg_pattern(cfg_pattern),
        .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_in_valid(in_valid),
        .i_in_bit(in_bit), .o_match(match1), .o_cfg_err(err1)
`ifdef SEQ_DET_MATCH_CNT_EN
        , .o_match_cnt(cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // last m_len received bits (plus the current one) compared against the pattern
    function automatic bit window_hit(input bit b);
        int unsigned val;
        int unsigned want;
        val  = b;
        for (int i = 1; i < m_len; i++)
            val |= int'(fresh[fresh.size() - i]) << i;
        want = m_pat & ((1 << m_len) - 1);
        return val == want;
    endfunction

    task automatic model_reset();
        m_cfgd = 0; m_err = 0; m_pat = 0; m_len = 0; m_ovl = 0; m_prev = 0;
        fresh.delete(); m_cnt0 = 0; m_cnt1 = 0;
    endtask

    task automatic check_outputs(input bit exp_now);
        chk("match_mealy", match0, exp_now);
        chk("match_reg",   match1, m_prev);
        chk("cfg_err0",    err0,   m_err);
        chk("cfg_err1",    err1,   m_err);
`ifdef SEQ_DET_MATCH_CNT_EN
        chk("cnt16", cnt0, m_cnt0);
        chk("cnt2",  cnt1, m_cnt1);
`endif
    endtask

    // One clock: entered 1 time unit after a rising edge, leaves the same way
    task automatic step(input bit ld, input bit [7:0] pat, input int len, input bit ovl,
                        input bit v, input bit b);
        bit exp_now;
        cfg_load = ld; cfg_pattern = pat; cfg_len = 4'(len); cfg_overlap = ovl;
        in_valid = v; in_bit = b;
        exp_now = 0;
        if (m_cfgd && v && !ld && (fresh.size() + 1 >= m_len))
            exp_now = window_hit(b);
        @(negedge clk);
        check_outputs(exp_now);
        if (match0 === 1'b1) hits0++;
        if (match1 === 1'b1) hits1++;
        @(posedge clk);
        if (ld) begin
            m_cfgd = (len >= 1 && len <= 8);
            m_err  = !m_cfgd;
            m_pat  = pat; m_len = len; m_ovl = ovl;
            fresh.delete(); m_cnt0 = 0; m_cnt1 = 0;
        end else if (m_cfgd && v) begin
            if (exp_now && !m_ovl) fresh.delete();
            else begin
                fresh.push_back(b);
                if (fresh.size() > 8) void'(fresh.pop_front());
            end
            if (exp_now) begin
                if (m_cnt0 < 65535) m_cnt0++;
                if (m_cnt1 < 3) m_cnt1++;
            end
        end
        m_prev = exp_now;
        #1;
    endtask

    task automatic load(input bit [7:0] pat, input int len, input bit ovl);
        step(1, pat, len, ovl, 0, 0);
    endtask

    task automatic bits(input bit [7:0] seq, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            step(0, 0, 0, 0, 1, seq[i]);
            if (gaps) step(0, 0, 0, 0, 0, ~seq[i]);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rstn = 0; cfg_load = 0; in_valid = 0;
        #2;
        model_reset();
        check_outputs(0);
        rstn = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 0; cfg_load = 0; cfg_pattern = 0; cfg_len = 0; cfg_overlap = 0;
        in_valid = 0; in_bit = 0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs(0);
        rstn = 1;
        @(posedge clk);
        #1;

        // unconfigured: a matching-looking stream never fires
        bits(8'b1010, 4, 0);
        chk("idle_hits", hits0, 0);

        // 1: overlapping 1010 on 101010
        hits0 = 0;
        load(8'b1010, 4, 1);
        bits(8'b101010, 6, 0);
        chk("t1_hits", hits0, 2);

        // 2: non-overlapping 1010 on 10101010
        hits0 = 0;
        load(8'b1010, 4, 0);
        bits(8'b10101010, 8, 0);
        chk("t2_hits", hits0, 2);

        // 3: all ones, full length, nine ones
        hits0 = 0;
        load(8'hFF, 8, 1);
        bits(8'hFF, 8, 0);
        bits(8'h01, 1, 0);
        chk("t3_hits", hits0, 2);
`ifdef SEQ_DET_MATCH_CNT_EN
        idle();
        chk("t3_cnt", cnt0, 2);
`endif

        // 4: illegal lengths latch cfg_err and block matching
        hits0 = 0;
        load(8'b1010, 0, 1);
        chk("t4_err_len0", err0, 1);
        bits(8'b1010, 4, 0);
        load(8'b1010, 9, 1);
        chk("t4_err_len9", err0, 1);
        bits(8'b1010, 4, 0);
        chk("t4_hits", hits0, 0);
        load(8'b1010, 4, 1);
        chk("t4_err_clr", err0, 0);

        // load with a valid bit in the same cycle: bit discarded
        hits0 = 0;
        bits(8'b101, 3, 0);
        step(1, 8'b1010, 4, 1, 1, 0);
        bits(8'b010, 3, 0);
        chk("load_wins_hits", hits0, 0);

        // 5: gaps between every bit are transparent; registered copy lags one cycle
        hits0 = 0; hits1 = 0;
        load(8'b1010, 4, 1);
        bits(8'b1010, 4, 1);
        idle();
        chk("t5_hits_mealy", hits0, 1);
        chk("t5_hits_reg", hits1, 1);

        // 6: reset mid-stream forgets configuration and history
        hits0 = 0;
        load(8'b1010, 4, 1);
        bits(8'b101, 3, 0);
        do_reset();
        bits(8'b0, 1, 0);
        bits(8'b1010, 4, 0);
        chk("t6_rst_hits", hits0, 0);

        // length-1 pattern, five hits, saturating narrow counter
        hits0 = 0;
        load(8'h01, 1, 1);
        bits(8'h1F, 5, 0);
        idle();
        chk("t6_len1_hits", hits0, 5);
`ifdef SEQ_DET_MATCH_CNT_EN
        chk("t6_cnt16", cnt0, 5);
        chk("t6_cnt_sat", cnt1, 3);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 29) == 0) begin
                int len;
                len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9))
                                                  : int'($urandom_range(1, 4));
                step(1, 8'($urandom), len, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(0, 0, 0, 0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
